// File: rtl/soc_rst_pkg.sv
// Shared definitions for the SoC reset sequencer: state encoding, default timing, width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package soc_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_LOCK  = 3'd1,
        ST_REL   = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } rst_state_e;

    localparam int unsigned DEF_NUM_STAGES  = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 8;
    localparam int unsigned DEF_STAGE_DLY   = 16;
    localparam int unsigned DEF_TIMEOUT     = 1024;

    // Bits needed to hold values 0..v-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter; o_expired is high while the count sits at zero.
// Latency: load/decrement take effect on the next clk edge; o_expired follows the register.
// Backpressure: none; i_load wins over i_en, and the count stops at zero.
// Ports: clk, rst_i (sync, active-high, reloads RST_VAL), i_load/i_load_val (reload),
//        i_en (decrement enable), o_expired (count == 0).
module rst_seq_timer #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset controller: releases NUM_STAGES resets in ascending order, gated by PLL lock and per-stage acks.
// Latency: all outputs registered; stage 0 releases HOLD_CYCLES+1 edges after the last reset cause at the earliest.
// Backpressure: a missing stage ack stalls the sequence indefinitely (or until timeout when RST_SEQ_TIMEOUT_EN is defined).
// Ports: clk, rst_i (sync active-high), pll_locked_i, sw_rst_req_i, stage_ack_i[NUM_STAGES];
//        rst_o[NUM_STAGES] (1 = held), done_o, cur_stage_o, err_o, fault_stage_o.
// Optional macro RST_SEQ_TIMEOUT_EN adds a wait timeout with a sticky FAULT state.
module reset_sequencer
    import soc_rst_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned STAGE_DLY   = DEF_STAGE_DLY,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                rst_i,
    input  logic                                pll_locked_i,
    input  logic                                sw_rst_req_i,
    input  logic [NUM_STAGES-1:0]               stage_ack_i,
    output logic [NUM_STAGES-1:0]               rst_o,
    output logic                                done_o,
    output logic [clog2(NUM_STAGES+1)-1:0]      cur_stage_o,
    output logic                                err_o,
    output logic [clog2(NUM_STAGES+1)-1:0]      fault_stage_o
);

    localparam int unsigned SW    = clog2(NUM_STAGES + 1);
    // One width covers every interval either timer may be loaded with.
    localparam int unsigned TMR_W = clog2(max3(HOLD_CYCLES, STAGE_DLY, TIMEOUT));

    localparam logic [SW-1:0]    LAST_IDX = SW'(NUM_STAGES - 1);
    localparam logic [SW-1:0]    DONE_IDX = SW'(NUM_STAGES);
    // Timers count down to zero, so an N-edge interval loads N-1.
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAGE_LD = TMR_W'(STAGE_DLY - 1);

    rst_state_e            r_state,  w_state_nxt;
    logic [SW-1:0]         r_stage,  w_stage_nxt;   // k of REL(k); NUM_STAGES in RUN
    logic [NUM_STAGES-1:0] r_rst,    w_rst_nxt;
    logic                  r_done,   w_done_nxt;

    logic                  w_cause;
    logic                  w_ack;
    logic                  w_dly_load;
    logic [TMR_W-1:0]      w_dly_val;
    logic                  w_dly_exp;

    // Ack of the stage currently released last.
    always_comb begin
        w_ack = 1'b0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            if (r_stage == SW'(k)) begin
                w_ack = stage_ack_i[k];
            end
        end
    end

    assign w_cause = (sw_rst_req_i && (r_state != ST_FAULT)) ||
                     (!pll_locked_i && ((r_state == ST_REL) || (r_state == ST_RUN)));

    rst_seq_timer #(
        .W       (TMR_W),
        .RST_VAL (HOLD_LD)
    ) u_dly_timer (
        .clk        (clk),
        .rst_i      (rst_i),
        .i_load     (w_dly_load),
        .i_load_val (w_dly_val),
        .i_en       (1'b1),
        .o_expired  (w_dly_exp)
    );

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(TIMEOUT - 1);

    logic          r_err,         w_err_nxt;
    logic [SW-1:0] r_fault_stage, w_fault_stage_nxt;
    logic          w_waiting;
    logic          w_wait_load;
    logic          w_wait_exp;

    // Waiting means blocked on something external: lock, or the ack after the delay ran out.
    assign w_waiting   = ((r_state == ST_LOCK) && !pll_locked_i) ||
                         ((r_state == ST_REL) && w_dly_exp && !w_ack);
    assign w_wait_load = !w_waiting || (w_state_nxt != r_state) || (w_stage_nxt != r_stage);

    rst_seq_timer #(
        .W       (TMR_W),
        .RST_VAL (TMO_LD)
    ) u_wait_timer (
        .clk        (clk),
        .rst_i      (rst_i),
        .i_load     (w_wait_load),
        .i_load_val (TMO_LD),
        .i_en       (w_waiting),
        .o_expired  (w_wait_exp)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_rst_nxt   = r_rst;
        w_done_nxt  = r_done;
        w_dly_load  = 1'b0;
        w_dly_val   = HOLD_LD;
`ifdef RST_SEQ_TIMEOUT_EN
        w_err_nxt         = r_err;
        w_fault_stage_nxt = r_fault_stage;
`endif
        if (w_cause) begin
            w_state_nxt = ST_HOLD;
            w_stage_nxt = '0;
            w_rst_nxt   = '1;
            w_done_nxt  = 1'b0;
            w_dly_load  = 1'b1;
            w_dly_val   = HOLD_LD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_dly_exp) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (pll_locked_i) begin
                        // rst_o is a thermometer of held stages; shifting left releases the next one.
                        w_state_nxt = ST_REL;
                        w_stage_nxt = '0;
                        w_rst_nxt   = {r_rst[NUM_STAGES-2:0], 1'b0};
                        w_dly_load  = 1'b1;
                        w_dly_val   = STAGE_LD;
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (w_wait_exp) begin
                        w_state_nxt       = ST_FAULT;
                        w_rst_nxt         = '1;
                        w_err_nxt         = 1'b1;
                        w_fault_stage_nxt = DONE_IDX;
                    end
`endif
                end
                ST_REL: begin
                    if (w_dly_exp && w_ack) begin
                        if (r_stage == LAST_IDX) begin
                            w_state_nxt = ST_RUN;
                            w_stage_nxt = DONE_IDX;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_stage_nxt = r_stage + SW'(1);
                            w_rst_nxt   = {r_rst[NUM_STAGES-2:0], 1'b0};
                            w_dly_load  = 1'b1;
                            w_dly_val   = STAGE_LD;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (w_dly_exp && w_wait_exp) begin
                        w_state_nxt       = ST_FAULT;
                        w_rst_nxt         = '1;
                        w_err_nxt         = 1'b1;
                        w_fault_stage_nxt = r_stage;
                    end
`endif
                end
                ST_RUN: begin
                    w_done_nxt = 1'b1;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                ST_FAULT: begin
                    // Only software can restart; the error flag survives.
                    if (sw_rst_req_i) begin
                        w_state_nxt = ST_HOLD;
                        w_stage_nxt = '0;
                        w_rst_nxt   = '1;
                        w_dly_load  = 1'b1;
                        w_dly_val   = HOLD_LD;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_stage_nxt = '0;
                    w_rst_nxt   = '1;
                    w_done_nxt  = 1'b0;
                    w_dly_load  = 1'b1;
                    w_dly_val   = HOLD_LD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= ST_HOLD;
            r_stage <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_rst   <= w_rst_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_err         <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            r_err         <= w_err_nxt;
            r_fault_stage <= w_fault_stage_nxt;
        end
    end

    assign err_o         = r_err;
    assign fault_stage_o = r_fault_stage;
`else
    assign err_o         = 1'b0;
    assign fault_stage_o = '0;
`endif

    assign rst_o       = r_rst;
    assign done_o      = r_done;
    assign cur_stage_o = r_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (4 stages, hold 8, stage delay 16, timeout 64).
// Latency: edge-numbered stimulus; edge 1 is the first rising edge with rst_i low.
// Backpressure: ack stalls and lock delays are driven from per-edge stimulus variables.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       sw_rst_req_i = 1'b0;
    logic [3:0] stage_ack_i = 4'h0;
    logic [3:0] rst_o;
    logic       done_o;
    logic [2:0] cur_stage_o;
    logic       err_o;
    logic [2:0] fault_stage_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ec       = 0;
    int lock_edge = 1;
    logic [3:0] ack_base = 4'hF;
    int ack1_edge = 0;
    int rel_e[4];
    int done_e;
    int bad_order = 0;
    logic exp_err;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES  (4),
        .HOLD_CYCLES (8),
        .STAGE_DLY   (16),
        .TIMEOUT     (64)
    ) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .pll_locked_i  (pll_locked_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .stage_ack_i   (stage_ack_i),
        .rst_o         (rst_o),
        .done_o        (done_o),
        .cur_stage_o   (cur_stage_o),
        .err_o         (err_o),
        .fault_stage_o (fault_stage_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic clr_rec();
        for (int k = 0; k < 4; k++) rel_e[k] = -1;
        done_e = -1;
    endtask

    // Runs until edge n, driving lock/acks for each edge and logging first release edges.
    task automatic measure(input int n);
        logic [3:0] sh;
        while (ec < n) begin
            pll_locked_i = (ec + 1 >= lock_edge);
            stage_ack_i  = ack_base | ((ec + 1 >= ack1_edge) ? 4'b0010 : 4'b0000);
            tick();
            for (int k = 0; k < 4; k++) begin
                if (rel_e[k] < 0 && rst_o[k] == 1'b0) rel_e[k] = ec;
            end
            if (done_e < 0 && done_o == 1'b1) done_e = ec;
            sh = rst_o << 1;
            if ((sh & ~rst_o) != 4'h0) bad_order++;
        end
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        sw_rst_req_i = 1'b0;
        repeat (3) tick();
        check("rst_rst_o", 32'(rst_o), 32'hF);
        check("rst_done", 32'(done_o), 0);
        check("rst_cur", 32'(cur_stage_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_fault", 32'(fault_stage_o), 0);
        rst_i = 1'b0;
        ec    = 0;
        clr_rec();
    endtask

    initial begin
        clr_rec();

        // Nominal sequence
        lock_edge = 1; ack_base = 4'hF; ack1_edge = 0;
        do_reset();
        measure(80);
        check("nom_rel0", rel_e[0], 9);
        check("nom_rel1", rel_e[1], 25);
        check("nom_rel2", rel_e[2], 41);
        check("nom_rel3", rel_e[3], 57);
        check("nom_done", done_e, 73);
        check("nom_cur", 32'(cur_stage_o), 4);
        check("nom_rst_o", 32'(rst_o), 0);

        // Late PLL lock
        lock_edge = 30;
        do_reset();
        measure(100);
        check("late_rel0", rel_e[0], 30);
        check("late_rel1", rel_e[1], 46);
        check("late_rel2", rel_e[2], 62);
        check("late_rel3", rel_e[3], 78);
        check("late_done", done_e, 94);

        // Stage 1 ack held low until edge 100
        lock_edge = 1; ack_base = 4'b1101; ack1_edge = 100;
        do_reset();
        measure(90);
        check("stall_cur_wait", 32'(cur_stage_o), 1);
        check("stall_rst_wait", 32'(rst_o), 32'hC);
        measure(110);
        check("stall_rel2", rel_e[2], 100);
        check("stall_cur_after", 32'(cur_stage_o), 2);
        check("stall_rst_after", 32'(rst_o), 32'h8);
        measure(140);
        check("stall_rel3", rel_e[3], 116);
        check("stall_done", done_e, 132);

        // PLL loss for one cycle in RUN, then full replay
        pll_locked_i = 1'b0;
        tick();
        check("loss_rst_o", 32'(rst_o), 32'hF);
        check("loss_done", 32'(done_o), 0);
        check("loss_cur", 32'(cur_stage_o), 0);
        clr_rec();
        ack_base = 4'hF; ack1_edge = 0;
        measure(220);
        check("loss_rel0", rel_e[0], 150);
        check("loss_rel1", rel_e[1], 166);
        check("loss_rel2", rel_e[2], 182);
        check("loss_rel3", rel_e[3], 198);
        check("loss_done_e", done_e, 214);

        // Software reset in REL(2) on the very edge stage 2's ack would advance
        do_reset();
        measure(56);
        check("sw_cur_before", 32'(cur_stage_o), 2);
        check("sw_rst_before", 32'(rst_o), 32'h8);
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        check("sw_rst_o", 32'(rst_o), 32'hF);
        check("sw_cur", 32'(cur_stage_o), 0);
        check("sw_done", 32'(done_o), 0);
        clr_rec();
        measure(58);
        check("sw_rst_hold", 32'(rst_o), 32'hF);
        measure(70);
        check("sw_rel0", rel_e[0], 66);
        check("sw_rel1", rel_e[1], -1);

        // Stage 0 ack stuck low
        ack_base = 4'b1110;
        do_reset();
        measure(200);
`ifdef RST_SEQ_TIMEOUT_EN
        exp_err = 1'b1;
        check("stuck_rst_o", 32'(rst_o), 32'hF);
`else
        exp_err = 1'b0;
        check("stuck_rst_o", 32'(rst_o), 32'hE);
        check("stuck_cur", 32'(cur_stage_o), 0);
`endif
        check("stuck_err", 32'(err_o), 32'(exp_err));
        check("stuck_fault", 32'(fault_stage_o), 0);
        check("stuck_done", 32'(done_o), 0);
        sw_rst_req_i = 1'b1;
        ack_base     = 4'hF;
        stage_ack_i  = 4'hF;
        tick();
        sw_rst_req_i = 1'b0;
        check("resq_rst_o", 32'(rst_o), 32'hF);
        clr_rec();
        measure(215);
        check("resq_rel0", rel_e[0], 210);
        check("resq_err", 32'(err_o), 32'(exp_err));

        check("release_order", bad_order, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
